// File: rtl/led_wave_seq.sv
`default_nettype none
// ============================================================================
// Module   : led_wave_seq
// Purpose  : Travelling "breathing" wave duty sequencer for a PWM LED bank.
//            Double-buffered, committed only on PWM period boundaries.
// Option   : define LED_SEQ_GAMMA_EN for perceptual correction (+1 stage).
// Revision : 1.0  initial release
// ============================================================================
module led_wave_seq #(
    parameter int MAIN_FREQ  = 50000000,
    parameter int STEP_HZ    = 100,
    parameter int S_CNT      = 200,
    parameter int N_CH       = 18,
    parameter int PHASE_STEP = 20
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              run,
    input  logic              tri_mode,
    input  logic              period_start,
    output logic [8*N_CH-1:0] duty_flat,
    output logic              step_tick,
    output logic [7:0]        phase
);
    localparam int            TDIV    = MAIN_FREQ / STEP_HZ - 1;
    localparam int            PW      = (TDIV < 1) ? 1 : $clog2(TDIV + 1);
    localparam logic [PW-1:0] C_TDIV  = PW'(TDIV);
    localparam logic [8:0]    C_P_SAW = 9'(S_CNT);
    localparam logic [8:0]    C_P_TRI = 9'(2 * (S_CNT - 1));
    localparam logic [8:0]    C_SCNT  = 9'(S_CNT);
    localparam logic [9:0]    C_PSTEP = 10'(PHASE_STEP);

    logic [PW-1:0]     presc_q, presc_d;
    logic              tick_q, tick_d;
    logic [8:0]        p_q, p_d;
    logic              mode_q, mode_d;
    logic [8*N_CH-1:0] pend_q, pend_d;
    logic [8*N_CH-1:0] duty_q;
    logic [8*N_CH-1:0] w_lin;
    logic [8:0]        w_period;
    logic              w_step;

    // Triangle period exceeds 255 for large S_CNT, so the phase is kept 9 bits wide.
    assign w_period = mode_q ? C_P_TRI : C_P_SAW;
    assign w_step   = run && (presc_q == C_TDIV);

    always_comb begin
        presc_d = presc_q;
        tick_d  = w_step;
        p_d     = p_q;
        mode_d  = mode_q;
        if (run) begin
            presc_d = w_step ? '0 : presc_q + PW'(1);
        end
        if (w_step) begin
            if (tri_mode != mode_q) begin
                p_d    = '0;
                mode_d = tri_mode;
            end else if (p_q == w_period - 9'd1) begin
                p_d = '0;
            end else begin
                p_d = p_q + 9'd1;
            end
        end
    end

    always_comb begin : chain
        logic [9:0] acc;
        logic [8:0] q;
        acc   = {1'b0, p_q};
        q     = '0;
        w_lin = '0;
        for (int i = 0; i < N_CH; i++) begin
            q = acc[8:0];
            if (mode_q && (q >= C_SCNT)) begin
                w_lin[8*i +: 8] = 8'(w_period - q);
            end else begin
                w_lin[8*i +: 8] = q[7:0];
            end
            acc = {1'b0, q} + C_PSTEP;
            if (acc >= {1'b0, w_period}) begin
                acc = acc - {1'b0, w_period};
            end
        end
    end

`ifdef LED_SEQ_GAMMA_EN
    localparam logic [33:0] C_RECIP = 34'((65536 + S_CNT - 2) / (S_CNT - 1));
    localparam logic [17:0] C_VMAX  = 18'(S_CNT - 1);

    logic [8*N_CH-1:0] lin_q;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            lin_q <= '0;
        end else begin
            lin_q <= w_lin;
        end
    end

    always_comb begin : gamma
        logic [33:0] prod;
        logic [17:0] g;
        prod   = '0;
        g      = '0;
        pend_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            prod = 34'(lin_q[8*i +: 8]) * 34'(lin_q[8*i +: 8]) * C_RECIP;
            g    = 18'(prod >> 16);
            if (g > C_VMAX) begin
                g = C_VMAX;
            end
            pend_d[8*i +: 8] = g[7:0];
        end
    end
`else
    assign pend_d = w_lin;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            p_q     <= '0;
            mode_q  <= tri_mode;
            pend_q  <= '0;
            duty_q  <= '0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            p_q     <= p_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            // Pending written on this same edge is not seen: the old buffer commits.
            if (period_start) begin
                duty_q <= pend_q;
            end
        end
    end

    assign duty_flat = duty_q;
    assign step_tick = tick_q;
    assign phase     = p_q[7:0];

endmodule
`default_nettype wire
